// File: rtl/nbit_mux_arbiter.sv
// Round-robin owner of a shared 2^SELECT_WIDTH:1 bit mux; grant/mux_sel one cycle after req, one dead cycle per handoff.
// No backpressure: a grant ends on req drop or hold expiry; mux_out is combinational from mux_in.

module nbit_mux #(
    parameter int SELECT_WIDTH = 1
) (
    input  logic [2**SELECT_WIDTH-1:0] MuxIn,
    input  logic [SELECT_WIDTH-1:0]    MuxSel,
    output logic                       MuxOut
);
    assign MuxOut = MuxIn[MuxSel];
endmodule

module nbit_mux_arbiter #(
    parameter int SELECT_WIDTH = 1,
    parameter int MAX_HOLD     = 4,
    parameter int HOLD_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2**SELECT_WIDTH-1:0] req,
    input  logic [2**SELECT_WIDTH-1:0] mux_in,
    output logic [2**SELECT_WIDTH-1:0] grant,
    output logic [SELECT_WIDTH-1:0]    mux_sel,
    output logic                       mux_out,
    output logic                       busy
);
    localparam int N = 2**SELECT_WIDTH;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_WIDTH'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_nxt;
    logic [N-1:0]            grant_nxt;
    logic [SELECT_WIDTH-1:0] sel_nxt;
    logic [SELECT_WIDTH-1:0] ptr, ptr_nxt;
    logic [SELECT_WIDTH-1:0] cand;
    logic [HOLD_WIDTH-1:0]   hold_cnt, hold_nxt;
    logic                    found;
    logic                    mux_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            mux_sel  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            mux_sel  <= sel_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = mux_sel;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        cand      = '0;
        found     = 1'b0;
        case (state)
            IDLE: begin
                // Scan starting at ptr so the last owner goes to the back of the line.
                for (int k = 0; k < N; k++) begin
                    cand = ptr + SELECT_WIDTH'(k);
                    if (!found && req[cand]) begin
                        found   = 1'b1;
                        sel_nxt = cand;
                    end
                end
                if (found) begin
                    grant_nxt          = '0;
                    grant_nxt[sel_nxt] = 1'b1;
                    hold_nxt           = '0;
                    state_nxt          = BUSY;
                end
            end
            BUSY: begin
                if (!req[mux_sel] || (MAX_HOLD != 0 && hold_cnt == HOLD_LAST)) begin
                    grant_nxt = '0;
                    ptr_nxt   = mux_sel + SELECT_WIDTH'(1);
                    state_nxt = IDLE;
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + HOLD_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    nbit_mux #(.SELECT_WIDTH(SELECT_WIDTH)) u_mux (
        .MuxIn  (mux_in),
        .MuxSel (mux_sel),
        .MuxOut (mux_bit)
    );

    assign busy    = (state == BUSY);
    assign mux_out = busy & mux_bit;

endmodule

// File: tb/tb_nbit_mux_arbiter.sv
// Bench: a limited-hold arbiter and an unlimited one share stimulus and are compared to a round-robin model.
module tb_nbit_mux_arbiter;
    localparam int SW = 2;
    localparam int N  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] mux_in;

    logic [N-1:0]  grant_a, grant_b;
    logic [SW-1:0] sel_a, sel_b;
    logic          out_a, out_b, busy_a, busy_b;

    int tests  = 0;
    int errors = 0;

    // model state, index 0 = MAX_HOLD 4, index 1 = unlimited
    int lim   [2] = '{4, 0};
    int m_busy[2];
    int m_own [2];
    int m_len [2];
    int m_ptr [2];
    int m_sel [2];

    typedef struct {
        logic [N-1:0] r;
        int           n;
    } phase_t;
    phase_t phases[$];

    always #5 clk = ~clk;

    nbit_mux_arbiter #(.SELECT_WIDTH(SW), .MAX_HOLD(4), .HOLD_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .mux_in(mux_in),
        .grant(grant_a), .mux_sel(sel_a), .mux_out(out_a), .busy(busy_a)
    );

    nbit_mux_arbiter #(.SELECT_WIDTH(SW), .MAX_HOLD(0), .HOLD_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .req(req), .mux_in(mux_in),
        .grant(grant_b), .mux_sel(sel_b), .mux_out(out_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_own[d] = 0; m_len[d] = 0; m_ptr[d] = 0; m_sel[d] = 0;
        end
    endtask

    task automatic model_step();
        bit found;
        int i;
        for (int d = 0; d < 2; d++) begin
            if (m_busy[d] != 0) begin
                if (!req[m_own[d]] || (lim[d] != 0 && m_len[d] == lim[d])) begin
                    m_busy[d] = 0;
                    m_ptr[d]  = (m_own[d] + 1) % N;
                end else begin
                    m_len[d]++;
                end
            end else if (req != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[d] + k) % N;
                    if (!found && req[i]) begin
                        found     = 1;
                        m_own[d]  = i;
                        m_sel[d]  = i;
                        m_busy[d] = 1;
                        m_len[d]  = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant(int d);
        logic [N-1:0] g;
        g = '0;
        if (m_busy[d] != 0) g[m_own[d]] = 1'b1;
        return g;
    endfunction

    function automatic logic exp_out(int d);
        return (m_busy[d] != 0) ? mux_in[m_own[d]] : 1'b0;
    endfunction

    task automatic check_all();
        check("a.grant",   32'(grant_a), 32'(exp_grant(0)));
        check("a.mux_sel", 32'(sel_a),   32'(m_sel[0]));
        check("a.busy",    32'(busy_a),  32'(m_busy[0]));
        check("a.mux_out", 32'(out_a),   32'(exp_out(0)));
        check("b.grant",   32'(grant_b), 32'(exp_grant(1)));
        check("b.mux_sel", 32'(sel_b),   32'(m_sel[1]));
        check("b.busy",    32'(busy_b),  32'(m_busy[1]));
        check("b.mux_out", 32'(out_b),   32'(exp_out(1)));
        check("a.onehot",  32'($countones(grant_a) <= 1), 32'd1);
    endtask

    initial begin
        int cyc;
        rst    = 1'b1;
        req    = '0;
        mux_in = 4'b1111;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        phases.push_back('{4'b0100, 6});
        phases.push_back('{4'b0000, 2});
        phases.push_back('{4'b1111, 26});
        phases.push_back('{4'b1001, 14});
        phases.push_back('{4'b0000, 2});
        phases.push_back('{4'b0010, 100});
        phases.push_back('{4'b0000, 3});
        phases.push_back('{4'b1111, 12});
        for (int p = 0; p < 120; p++)
            phases.push_back('{4'($urandom_range(0, 15)), int'($urandom_range(1, 14))});

        cyc = 0;
        foreach (phases[p]) begin
            for (int c = 0; c < phases[p].n; c++) begin
                check_all();
                req    = phases[p].r;
                mux_in = 4'($urandom_range(0, 15));
                #1;
                check("a.mux_out_comb", 32'(out_a), 32'(exp_out(0)));
                check("b.mux_out_comb", 32'(out_b), 32'(exp_out(1)));
                cyc++;
                if (cyc == 160 || cyc == 700) begin
                    req = 4'b1111;
                    #2 rst = 1'b1;
                    #1;
                    model_reset();
                    check_all();
                    @(posedge clk);
                    @(negedge clk);
                    check_all();
                    rst = 1'b0;
                    #1;
                end
                @(posedge clk);
                model_step();
                @(negedge clk);
            end
        end
        check_all();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
